gddr_word_align: RTL and testbench
==================================

Name: gddr_word_align

Overview:
- Downstream neighbour of the clock-sync controller. Starts after its `ready` output goes high.
- Trains the deserialized DDR receive word to a known pattern. It does this by pulsing the IDDR ALIGNWD (word-slip) input until the parallel word matches the pattern for a set number of consecutive cycles.
- Reports lock or failure to the user logic.
- Runs entirely in the `sync_clk` domain; `rx_data` is already registered into this domain.

Parameters:
- DATA_WIDTH, 8, deserialized word width; legal range 2..15.
- TRAIN_PATTERN, 8'hB4, expected training word; lower DATA_WIDTH bits used.
- SETTLE_CYC, 7, cycles to wait after entry/slip before comparing; minimum 1.
- MATCH_CNT, 4, consecutive matches required for lock; minimum 1.
- ERR_LIMIT, 3, consecutive mismatches that break lock; used only with the optional feature.

Ports:
- sync_clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- ready  in  1  clock-sync done, from the sync controller; level.
- train_en  in  1  request training; level.
- rx_data  in  DATA_WIDTH  deserialized receive word.
- alignwd  out  1  one-cycle word-slip pulse to IDDR ALIGNWD.
- aligned  out  1  lock achieved.
- align_err  out  1  all phases tried, no lock.
- slip_cnt  out  4  number of slips issued in the current attempt.

Interface decision: one clock (`sync_clk`); reset is asynchronous and active-high (`rst`).

Behaviour:
- Reset values:
  - Outputs: alignwd=0, aligned=0, align_err=0, slip_cnt=0.
  - State=IDLE; settle and match counters=0.
  - All outputs are registered or decoded directly from the state register; no combinational input-to-output paths.
- States and transitions:
  - IDLE: exit to SETTLE when ready=1 and train_en=1 in the same cycle. slip_cnt, settle counter and match counter are cleared on entry.
  - SETTLE: settle counter counts 0..SETTLE_CYC-1, then goes to CHECK. SETTLE lasts exactly SETTLE_CYC cycles.
  - CHECK: compare rx_data with TRAIN_PATTERN every cycle.
    - Match: match counter increments. A match when the count is MATCH_CNT-1 goes to LOCKED.
    - Mismatch: match counter clears. If slip_cnt==DATA_WIDTH-1, go to FAIL; otherwise go to SLIP.
  - SLIP: alignwd=1 for exactly this one cycle. slip_cnt increments; settle counter clears; go to SETTLE.
  - LOCKED: aligned=1. slip_cnt holds. rx_data is ignored (base build).
  - FAIL: align_err=1. slip_cnt holds. Stays in FAIL until train_en=0, then goes to IDLE.
- Abort: ready=0 or train_en=0 in any non-IDLE state forces IDLE on the next edge. Outputs clear in that cycle; slip_cnt clears. Abort has priority over all other transitions.
- Latency (everything matching, no slips):
  - ready&train_en sampled at edge 0.
  - SETTLE occupies cycles 1..SETTLE_CYC.
  - CHECK occupies the next MATCH_CNT cycles.
  - aligned=1 from cycle SETTLE_CYC+MATCH_CNT+1; with defaults, cycle 12.
- Spacing: consecutive alignwd pulses are at least SETTLE_CYC+1 cycles apart. alignwd is never asserted for two consecutive cycles.
- Retrain: after LOCKED or FAIL, a new attempt requires train_en to go low and then high again.

Optional Feature:
- Macro: GDDR_WORD_ALIGN_MONITOR_EN.
- Defined: LOCKED keeps comparing rx_data.
  - ERR_LIMIT consecutive mismatches drop aligned and go to SETTLE, with slip_cnt and match counter cleared. Training then restarts.
  - Any match clears the mismatch counter.
- Undefined: LOCKED holds regardless of rx_data. No mismatch counter is built.

Test Plan:
- Constant rx_data=8'hB4, ready=1, train_en=1 -> no alignwd pulse, aligned=1 at cycle 12, slip_cnt=0, align_err=0.
- Bench rotates a rotated-pattern word by one bit per alignwd, correct after 3 slips -> exactly 3 single-cycle alignwd pulses, each ≥8 cycles apart, then aligned=1, slip_cnt=3.
- rx_data=8'h00 constant -> 7 alignwd pulses, slip_cnt=7, then align_err=1, aligned=0. train_en low -> next cycle IDLE, align_err=0, slip_cnt=0.
- ready dropped during SETTLE after 2 slips -> next cycle all outputs 0, slip_cnt=0; no alignwd pulse issued afterwards.
- In CHECK, 2 matches then 1 mismatch -> one alignwd pulse, match counter restarts. Lock needs 4 fresh consecutive matches after the next SETTLE.
- MONITOR_EN defined, locked, ERR_LIMIT=3: 2 mismatches then a match -> aligned stays 1. 3 consecutive mismatches -> aligned=0 next cycle, SETTLE re-entered, slip_cnt=0.

Source files
------------

// File: rtl/gddr_word_align.sv
// ----------------------------------------------------------------------------
// gddr_word_align
//
// Trains the deserialized DDR receive word onto a known pattern. Once the
// clock-sync controller reports ready and training is requested, the block
// waits for the receive path to settle. It then compares the parallel word
// against TRAIN_PATTERN. Each mismatch issues one ALIGNWD word-slip pulse to
// the IDDR, and training continues until the pattern is seen on MATCH_CNT
// consecutive cycles (lock). If every word phase has been tried without a
// lock, the block reports failure.
//
// Ports:
//   sync_clk   in   single clock for all logic
//   rst        in   asynchronous, active-high reset
//   ready      in   clock-sync done (level)
//   train_en   in   training request (level)
//   rx_data    in   deserialized receive word, already in sync_clk domain
//   alignwd    out  one-cycle word-slip pulse to IDDR ALIGNWD
//   aligned    out  lock achieved
//   align_err  out  all phases tried, no lock
//   slip_cnt   out  slips issued in the current attempt
//
// Optional feature macro: GDDR_WORD_ALIGN_MONITOR_EN
//   When defined, the LOCKED state keeps watching rx_data. ERR_LIMIT
//   consecutive mismatches drop lock and restart training from SETTLE.
//   When undefined, LOCKED holds regardless of rx_data.
// ----------------------------------------------------------------------------
module gddr_word_align #(
    parameter int          DATA_WIDTH    = 8,
    parameter logic [14:0] TRAIN_PATTERN = 15'h00B4,
    parameter int          SETTLE_CYC    = 7,
    parameter int          MATCH_CNT     = 4,
    parameter int          ERR_LIMIT     = 3
) (
    input  logic                  sync_clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic                  train_en,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  alignwd,
    output logic                  aligned,
    output logic                  align_err,
    output logic [3:0]            slip_cnt
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int MATCH_W  = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;

    localparam logic [DATA_WIDTH-1:0] PATTERN     = TRAIN_PATTERN[DATA_WIDTH-1:0];
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [MATCH_W-1:0]    MATCH_LAST  = MATCH_W'(MATCH_CNT - 1);
    localparam logic [3:0]            SLIP_LAST   = 4'(DATA_WIDTH - 1);

    // Elaboration-time parameter legality checks
    if (DATA_WIDTH < 2 || DATA_WIDTH > 15) begin : gen_bad_width
        $error("gddr_word_align: DATA_WIDTH must be 2..15");
    end
    if (SETTLE_CYC < 1) begin : gen_bad_settle
        $error("gddr_word_align: SETTLE_CYC must be at least 1");
    end
    if (MATCH_CNT < 1) begin : gen_bad_match
        $error("gddr_word_align: MATCH_CNT must be at least 1");
    end
    if (ERR_LIMIT < 1) begin : gen_bad_errlimit
        $error("gddr_word_align: ERR_LIMIT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settleCnt_q, settleCnt_d;
    logic [MATCH_W-1:0]    matchCnt_q, matchCnt_d;
    logic [3:0]            slipCnt_q, slipCnt_d;

    logic abort;
    logic isMatch;
    logic settleDone;
    logic matchDone;
    logic lastPhase;

`ifdef GDDR_WORD_ALIGN_MONITOR_EN
    localparam int              ERR_W    = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);

    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic             errDone;

    assign errDone = (errCnt_q == ERR_LAST);
`endif

    // Losing ready or train_en outside IDLE overrides every other transition
    assign abort      = (state_q != IDLE) && !(ready && train_en);
    assign isMatch    = (rx_data == PATTERN);
    assign settleDone = (settleCnt_q == SETTLE_LAST);
    assign matchDone  = (matchCnt_q == MATCH_LAST);
    // Once DATA_WIDTH-1 slips have been issued, every word phase has been seen
    assign lastPhase  = (slipCnt_q == SLIP_LAST);

    always_ff @(posedge sync_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready && train_en) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settleDone) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (isMatch) begin
                        if (matchDone) begin
                            state_d = LOCKED;
                        end
                    end else if (lastPhase) begin
                        state_d = FAIL;
                    end else begin
                        state_d = SLIP;
                    end
                end
                SLIP: begin
                    state_d = SETTLE;
                end
                LOCKED: begin
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
                    if (!isMatch && errDone) begin
                        state_d = SETTLE;
                    end
`endif
                end
                // FAIL is left only through the abort path when train_en drops
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alignwd   = (state_q == SLIP);
        aligned   = (state_q == LOCKED);
        align_err = (state_q == FAIL);
    end

    assign slip_cnt = slipCnt_q;

    // Counter updates track the state being left; IDLE and abort hold them at zero
    always_comb begin
        settleCnt_d = settleCnt_q;
        matchCnt_d  = matchCnt_q;
        slipCnt_d   = slipCnt_q;
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
        errCnt_d    = errCnt_q;
`endif
        case (state_q)
            IDLE: begin
                settleCnt_d = '0;
                matchCnt_d  = '0;
                slipCnt_d   = '0;
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
                errCnt_d    = '0;
`endif
            end
            SETTLE: begin
                settleCnt_d = settleDone ? '0 : settleCnt_q + SETTLE_W'(1);
            end
            CHECK: begin
                matchCnt_d = (isMatch && !matchDone) ? matchCnt_q + MATCH_W'(1) : '0;
            end
            SLIP: begin
                slipCnt_d   = slipCnt_q + 4'd1;
                settleCnt_d = '0;
            end
            LOCKED: begin
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
                if (isMatch) begin
                    errCnt_d = '0;
                end else if (errDone) begin
                    errCnt_d    = '0;
                    slipCnt_d   = '0;
                    matchCnt_d  = '0;
                    settleCnt_d = '0;
                end else begin
                    errCnt_d = errCnt_q + ERR_W'(1);
                end
`endif
            end
            default: begin
            end
        endcase
        if (abort) begin
            settleCnt_d = '0;
            matchCnt_d  = '0;
            slipCnt_d   = '0;
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
            errCnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge sync_clk or posedge rst) begin
        if (rst) begin
            settleCnt_q <= '0;
            matchCnt_q  <= '0;
            slipCnt_q   <= '0;
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
            errCnt_q    <= '0;
`endif
        end else begin
            settleCnt_q <= settleCnt_d;
            matchCnt_q  <= matchCnt_d;
            slipCnt_q   <= slipCnt_d;
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
            errCnt_q    <= errCnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gddr_word_align.sv
// ----------------------------------------------------------------------------
// tb_gddr_word_align
//
// Self-checking bench for gddr_word_align. A behavioural model built from
// flags and countdowns predicts every output on every cycle. A channel model
// rotates the receive word by one bit per observed alignwd pulse, the way the
// IDDR word slip does. Directed scenarios cover lock latency, slipping,
// failure, abort and the lock monitor. Randomised trials add noise and
// random loss of ready.
// ----------------------------------------------------------------------------
module tb_gddr_word_align;

    localparam int         W      = 8;
    localparam logic [7:0] PAT    = 8'hB4;
    localparam int         SETTLE = 7;
    localparam int         MATCH  = 4;
    localparam int         ERRL   = 3;

    logic       sync_clk = 1'b0;
    logic       rst;
    logic       ready;
    logic       train_en;
    logic [7:0] rx_data;
    logic       alignwd;
    logic       aligned;
    logic       align_err;
    logic [3:0] slip_cnt;

    always #5 sync_clk = ~sync_clk;

    gddr_word_align #(
        .DATA_WIDTH   (W),
        .TRAIN_PATTERN(15'(PAT)),
        .SETTLE_CYC   (SETTLE),
        .MATCH_CNT    (MATCH),
        .ERR_LIMIT    (ERRL)
    ) dut (
        .sync_clk (sync_clk),
        .rst      (rst),
        .ready    (ready),
        .train_en (train_en),
        .rx_data  (rx_data),
        .alignwd  (alignwd),
        .aligned  (aligned),
        .align_err(align_err),
        .slip_cnt (slip_cnt)
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model: attempt flags plus a settle countdown and match streak
    bit mActive, mLocked, mFailed, mPulse;
    int mSettleLeft, mStreak, mSlips, mMiss;

    // Channel and scenario bookkeeping
    int         rxMode;
    logic [7:0] rxConst;
    int         offs;
    int         glitchAt;
    int         noisePct;
    int         sceneCycle;
    int         firstAligned;
    int         pulseCount;
    int         lastPulse;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h (scene cycle %0d)", tag, observed, expected, sceneCycle);
        end
    endtask

    function automatic logic [7:0] rotWord(input int k);
        logic [7:0] p;
        p = PAT;
        for (int i = 0; i < k; i++) begin
            p = {p[6:0], p[7]};
        end
        return p;
    endfunction

    task automatic modelReset();
        mActive     = 1'b0;
        mLocked     = 1'b0;
        mFailed     = 1'b0;
        mPulse      = 1'b0;
        mSettleLeft = 0;
        mStreak     = 0;
        mSlips      = 0;
        mMiss       = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelStep(input logic r, input logic t, input logic [7:0] d);
        if (!mActive) begin
            if (r && t) begin
                mActive     = 1'b1;
                mSettleLeft = SETTLE;
                mSlips      = 0;
                mStreak     = 0;
                mMiss       = 0;
            end
        end else if (!(r && t)) begin
            modelReset();
        end else if (mFailed) begin
        end else if (mLocked) begin
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
            if (d == PAT) begin
                mMiss = 0;
            end else begin
                mMiss++;
                if (mMiss == ERRL) begin
                    mLocked     = 1'b0;
                    mMiss       = 0;
                    mSlips      = 0;
                    mStreak     = 0;
                    mSettleLeft = SETTLE;
                end
            end
`endif
        end else if (mPulse) begin
            mPulse      = 1'b0;
            mSlips++;
            mSettleLeft = SETTLE;
        end else if (mSettleLeft > 0) begin
            mSettleLeft--;
        end else if (d == PAT) begin
            mStreak++;
            if (mStreak == MATCH) begin
                mLocked = 1'b1;
                mStreak = 0;
            end
        end else begin
            mStreak = 0;
            if (mSlips == W - 1) begin
                mFailed = 1'b1;
            end else begin
                mPulse = 1'b1;
            end
        end
    endtask

    task automatic driveRx();
        if (rxMode == 0) begin
            rx_data = rxConst;
        end else begin
            rx_data = rotWord(offs);
        end
        if (sceneCycle == glitchAt) begin
            rx_data = ~PAT;
        end
        if (noisePct > 0 && $urandom_range(99) < noisePct) begin
            rx_data = rx_data ^ 8'(1 << $urandom_range(7));
        end
    endtask

    task automatic startScene(input int mode, input logic [7:0] cval, input int startOffs, input int glitch, input int noise);
        rxMode       = mode;
        rxConst      = cval;
        offs         = startOffs;
        glitchAt     = glitch;
        noisePct     = noise;
        sceneCycle   = 0;
        firstAligned = -1;
        pulseCount   = 0;
        lastPulse    = -1;
        driveRx();
    endtask

    task automatic stepCycle();
        @(posedge sync_clk);
        modelStep(ready, train_en, rx_data);
        sceneCycle++;
        #1;
        checkOutput("alignwd", 32'(alignwd), 32'(mPulse));
        checkOutput("aligned", 32'(aligned), 32'(mLocked));
        checkOutput("align_err", 32'(align_err), 32'(mFailed));
        checkOutput("slip_cnt", 32'(slip_cnt), 32'(mSlips));
        if (aligned === 1'b1 && firstAligned < 0) begin
            firstAligned = sceneCycle;
        end
        if (alignwd === 1'b1) begin
            pulseCount++;
            if (lastPulse >= 0) begin
                checkOutput("pulse_gap", 32'((sceneCycle - lastPulse) > SETTLE), 32'd1);
            end
            lastPulse = sceneCycle;
            offs      = (offs + 1) % W;
        end
        driveRx();
    endtask

    task automatic applyStimulus(input logic r, input logic t, input int cycles);
        ready    = r;
        train_en = t;
        for (int i = 0; i < cycles; i++) begin
            stepCycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ready    = 1'b0;
        train_en = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        startScene(0, 8'h00, 0, -1, 0);

        // Reset state
        repeat (2) @(posedge sync_clk);
        #1;
        checkOutput("rst_alignwd", 32'(alignwd), 32'd0);
        checkOutput("rst_aligned", 32'(aligned), 32'd0);
        checkOutput("rst_align_err", 32'(align_err), 32'd0);
        checkOutput("rst_slip_cnt", 32'(slip_cnt), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3);

        // Constant pattern: lock with no slips at the nominal latency
        $display("[TB] scene: constant pattern");
        startScene(0, PAT, 0, -1, 0);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("lock_latency", 32'(firstAligned), 32'(SETTLE + MATCH + 1));
        checkOutput("no_slip_pulses", 32'(pulseCount), 32'd0);
        applyStimulus(1'b1, 1'b0, 3);

        // Rotated channel needing three slips
        $display("[TB] scene: three slips");
        startScene(1, 8'h00, W - 3, -1, 0);
        applyStimulus(1'b1, 1'b1, 60);
        checkOutput("three_pulses", 32'(pulseCount), 32'd3);
        checkOutput("three_slip_lock", 32'(firstAligned), 32'(3 * (SETTLE + 2) + SETTLE + MATCH + 1));
        checkOutput("three_slip_cnt", 32'(slip_cnt), 32'd3);
        applyStimulus(1'b1, 1'b0, 3);

        // All-zero data: every phase tried, then failure
        $display("[TB] scene: no lock possible");
        startScene(0, 8'h00, 0, -1, 0);
        applyStimulus(1'b1, 1'b1, 80);
        checkOutput("fail_pulses", 32'(pulseCount), 32'(W - 1));
        checkOutput("fail_flag", 32'(align_err), 32'd1);
        checkOutput("fail_slip_cnt", 32'(slip_cnt), 32'(W - 1));
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("fail_clear", 32'(align_err), 32'd0);
        checkOutput("fail_slip_clear", 32'(slip_cnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 2);

        // Loss of ready during SETTLE after two slips
        $display("[TB] scene: abort in settle");
        startScene(1, 8'h00, W - 5, -1, 0);
        for (int i = 0; i < 100 && pulseCount < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1);
        end
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("abort_pre_pulses", 32'(pulseCount), 32'd2);
        checkOutput("abort_pre_slips", 32'(slip_cnt), 32'd2);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("abort_slip_clear", 32'(slip_cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 20);
        checkOutput("abort_no_pulse", 32'(pulseCount), 32'd2);
        applyStimulus(1'b0, 1'b0, 2);

        // Two matches then one mismatch in CHECK restarts the streak
        $display("[TB] scene: broken match streak");
        startScene(0, PAT, 0, SETTLE + 3, 0);
        applyStimulus(1'b1, 1'b1, 35);
        checkOutput("streak_pulses", 32'(pulseCount), 32'd1);
        checkOutput("streak_lock", 32'(firstAligned), 32'(2 * SETTLE + MATCH + 5));
        checkOutput("streak_slips", 32'(slip_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 3);

        // Lock monitor: short error burst tolerated, long burst breaks lock
        $display("[TB] scene: lock monitor");
        startScene(0, PAT, 0, -1, 0);
        applyStimulus(1'b1, 1'b1, 14);
        rxConst = 8'h00;
        driveRx();
        applyStimulus(1'b1, 1'b1, ERRL - 1);
        rxConst = PAT;
        driveRx();
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("mon_lock_held", 32'(aligned), 32'd1);
        rxConst = 8'h00;
        driveRx();
        applyStimulus(1'b1, 1'b1, ERRL);
`ifdef GDDR_WORD_ALIGN_MONITOR_EN
        checkOutput("mon_lock_drop", 32'(aligned), 32'd0);
`else
        checkOutput("mon_lock_drop", 32'(aligned), 32'd1);
`endif
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 3);

        // Randomised trials: random phase, bit noise and brief ready drops
        $display("[TB] scene: random trials");
        for (int trial = 0; trial < 8; trial++) begin
            startScene(1, 8'h00, int'($urandom_range(W - 1)), -1, int'($urandom_range(8)));
            for (int c = 0; c < 120; c++) begin
                applyStimulus(logic'($urandom_range(99) >= 3), 1'b1, 1);
            end
            applyStimulus(1'b1, 1'b0, 3);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
